// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one combinational fp32 adder between N_REQ requesters.
// Operands and result are registered so the adder sits alone between two flop stages.
module fpadder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] s
);
  logic        sa, sb, sl, eff_sub, swap, a_nan, b_nan, a_inf, b_inf, rup;
  logic [7:0]  ea, eb, el, es, d, lim, nsh;
  logic [23:0] ma, mb, ml, ms, mr;
  logic [5:0]  dc;
  logic [49:0] sh;
  logic [26:0] al, sm_al, n;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  en, er;
  logic [24:0] m25;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ sub;
    ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma    = {a[30:23] != 8'd0, a[22:0]};
    mb    = {b[30:23] != 8'd0, b[22:0]};
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    swap  = b[30:0] > a[30:0];
    sl    = swap ? sb : sa;
    el    = swap ? eb : ea;
    es    = swap ? ea : eb;
    ml    = swap ? mb : ma;
    ms    = swap ? ma : mb;
    eff_sub = sa ^ sb;
    d     = el - es;
    dc    = (d > 8'd50) ? 6'd50 : d[5:0];
    // Guard, round and a sticky bit that collects everything shifted past them.
    sh    = {ms, 26'd0} >> dc;
    al    = {ml, 3'b000};
    sm_al = {sh[49:24], |sh[23:0]};
    sum   = eff_sub ? ({1'b0, al} - {1'b0, sm_al}) : ({1'b0, al} + {1'b0, sm_al});
    lz    = lzc27(sum[26:0]);
    lim   = el - 8'd1;
    if (sum[27]) begin
      n   = {sum[27:2], sum[1] | sum[0]};
      en  = {2'b00, el} + 10'd1;
      nsh = 8'd0;
    end else begin
      // Left shift stops at the minimum exponent so tiny results come out subnormal.
      nsh = ({3'b000, lz} > lim) ? lim : {3'b000, lz};
      n   = sum[26:0] << nsh;
      en  = {2'b00, el} - {2'b00, nsh};
    end
    rup = n[2] & (n[1] | n[0] | n[3]);
    m25 = {1'b0, n[26:3]} + {24'd0, rup};
    if (m25[24]) begin
      mr = m25[24:1];
      er = en + 10'd1;
    end else begin
      mr = m25[23:0];
      er = en;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      s = 32'h7FC00000;
    else if (a_inf)
      s = {sa, 8'hFF, 23'd0};
    else if (b_inf)
      s = {sb, 8'hFF, 23'd0};
    else if (sum == 28'd0)
      s = {sa & sb, 31'd0};
    else if (er >= 10'd255)
      s = {sl, 8'hFF, 23'd0};
    else
      s = {sl, mr[23] ? er[7:0] : 8'h00, mr[22:0]};
  end
endmodule

module fp_add_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0]    req_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_s,
  output logic                busy,
  output logic [15:0]         op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, win;
  logic [31:0]     opa_q, opa_d, opb_q, opb_d, res_q, res_d, add_s;
  logic            opsub_q, opsub_d, any_valid, can_grant, grant;
  logic [15:0]     cnt_q, cnt_d;
  int              idx;

  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = ID_W'(idx);
      end
    end
  end

  assign can_grant = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign grant     = can_grant && any_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = grant ? (N_REQ'(1) << win) : '0;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opsub_d = opsub_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    if (grant) begin
      ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
      id_d    = win;
      opa_d   = req_a[32*win +: 32];
      opb_d   = req_b[32*win +: 32];
      opsub_d = req_sub[win];
    end
    if (state_q == EXEC) res_d = add_s;
    if ((state_q == RESP) && rsp_ready) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opsub_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opsub_q <= opsub_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  fpadder u_add (
    .a   (opa_q),
    .b   (opb_q),
    .sub (opsub_q),
    .s   (add_s)
  );

  assign rsp_id   = id_q;
  assign rsp_s    = res_q;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with two requesters; expected responses are
// queued when a request is driven and compared in order as responses complete.
module tb_fp_add_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_sub;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, busy;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_s;
  logic [15:0] op_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [32:0] sb_q[$];
  int          rsp_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_add_arbiter #(.N_REQ(2), .ID_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_valid[i]        = 1'b1;
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
    req_sub[i]          = s;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'h0);
    chk({tag, "_rsp_s"},     rsp_s,          32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_op_count"},  32'(op_count),  32'h0);
  endtask

  // Entered one time unit after a rising edge; samples one unit later each cycle.
  task automatic run(input int ncyc);
    logic [1:0]  granted;
    logic [32:0] ex;
    for (int k = 0; k < ncyc; k++) begin
      #1;
      checks++;
      assert ($onehot0(req_ready) && ((req_ready & ~req_valid) == 2'b00)) else begin
        errors++;
        $error("FAIL ready_onehot observed=%b expected_subset_of=%b", req_ready, req_valid);
      end
      granted = req_valid & req_ready;
      if (rsp_valid && rsp_ready) begin
        $display("rsp id=%0d s=%h cycle=%0d", rsp_id, rsp_s, cyc);
        checks++;
        assert (sb_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_rsp observed id=%0d s=%h expected no response", rsp_id, rsp_s);
        end
        if (sb_q.size() != 0) begin
          ex = sb_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(ex[32]));
          chk("rsp_s", rsp_s, ex[31:0]);
        end
        rsp_cyc.push_back(cyc);
      end
      step();
      req_valid = req_valid & ~granted;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] ex;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // Single add with exact latency
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    sb_q.push_back({1'b0, 32'h40400000});
    step();
    req_valid = '0;
    #1;
    chk("t1_busy_exec", 32'(busy), 32'h1);
    chk("t1_no_early_rsp", 32'(rsp_valid), 32'h0);
    step();
    #1;
    chk("t1_latency", 32'(rsp_valid), 32'h1);
    chk("t1_cnt_before", 32'(op_count), 32'h0);
    ex = sb_q.pop_front();
    chk("t1_rsp_id", 32'(rsp_id), 32'(ex[32]));
    chk("t1_rsp_s", rsp_s, ex[31:0]);
    step();
    #1;
    chk("t1_cnt_after", 32'(op_count), 32'h1);
    chk("t1_idle", 32'(busy), 32'h0);
    step();

    // Subtract on requester 1
    set_req(1, 32'h43E20FCC, 32'h41AC8ADB, 1'b1);
    sb_q.push_back({1'b1, 32'h43D7471E});
    run(4);
    chk("t2_drained", 32'(sb_q.size()), 32'h0);

    // Exact cancellation gives +0
    set_req(0, 32'h3B67BA9D, 32'hBB67BA9D, 1'b0);
    sb_q.push_back({1'b0, 32'h00000000});
    run(4);
    chk("t3_drained", 32'(sb_q.size()), 32'h0);

    // Contention from reset, two rounds
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rsp_cyc.delete();
    for (int r = 0; r < 2; r++) begin
      set_req(0, 32'hBA9DBB67, 32'h4148F5CB, 1'b0);
      set_req(1, 32'hC49A522C, 32'h442987E6, 1'b0);
      sb_q.push_back({1'b0, 32'h4148F0DD});
      sb_q.push_back({1'b1, 32'hC40B1C72});
      run(7);
      chk("t4_drained", 32'(sb_q.size()), 32'h0);
      chk("t4_rsp_count", 32'(rsp_cyc.size()), 32'(2 * (r + 1)));
      if (rsp_cyc.size() == 2 * (r + 1))
        chk("t4_spacing", 32'(rsp_cyc[2*r+1] - rsp_cyc[2*r]), 32'd2);
    end

    // Backpressure with requester 1 waiting
    rsp_ready = 1'b0;
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    sb_q.push_back({1'b0, 32'h40400000});
    run(3);
    set_req(1, 32'h43E20FCC, 32'h41AC8ADB, 1'b1);
    sb_q.push_back({1'b1, 32'h43D7471E});
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_s", rsp_s, 32'h40400000);
      chk("bp_id", 32'(rsp_id), 32'h0);
      chk("bp_ready", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_grant_on_release", 32'(req_ready), 32'h2);
    run(5);
    chk("bp_drained", 32'(sb_q.size()), 32'h0);

    // Asynchronous reset while in EXEC
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    step();
    rst_n = 1'b1;
    run(5);
    chk("rst_cnt_cleared", 32'(op_count), 32'h0);
    set_req(1, 32'h43E20FCC, 32'h41AC8ADB, 1'b1);
    sb_q.push_back({1'b1, 32'h43D7471E});
    run(4);
    #1;
    chk("rst_cnt_restart", 32'(op_count), 32'h1);
    chk("rst_drained", 32'(sb_q.size()), 32'h0);
    step();

    // Requester 1 withdraws before it could be granted
    rsp_ready = 1'b0;
    set_req(0, 32'h3B67BA9D, 32'hBB67BA9D, 1'b0);
    sb_q.push_back({1'b0, 32'h00000000});
    run(3);
    set_req(1, 32'h3F800000, 32'h3F800000, 1'b0);
    run(2);
    req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    run(6);
    chk("drop_drained", 32'(sb_q.size()), 32'h0);
    chk("drop_cnt", 32'(op_count), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one combinational `fpadder` (fp32 add/subtract) instance between `N_REQ` requesters. Each requester presents operands on a valid/ready channel. The block registers the winning operands, drives the shared adder, registers the result, and returns it on a single tagged response channel. It sits between the requesting datapath blocks and the single adder, so the adder's combinational path is isolated between two register stages.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..8.
- `ID_W`, default 1: response tag width, must equal max(1, clog2(N_REQ)).
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input N_REQ: per-requester request valid.
- `req_ready` output N_REQ: per-requester accept; one-hot or zero.
- `req_a` input 32*N_REQ: operand a; requester i uses bits [32i+31:32i].
- `req_b` input 32*N_REQ: operand b, same packing.
- `req_sub` input N_REQ: 1 = a−b, 0 = a+b (drives adder `sub`).
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_id` output ID_W: index of the requester that owns the result.
- `rsp_s` output 32: fp32 result, bit-exact `fpadder` output.
- `busy` output 1: high when the FSM is not in IDLE.
- `op_count` output 16: count of completed responses; wraps at 16'hFFFF→0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **Grant:**
  - Round-robin pointer `ptr`, reset value 0.
  - The winner is the first i with `req_valid[i]`=1, searching ptr, ptr+1, … mod N_REQ.
  - On grant, `ptr` ← (winner+1) mod N_REQ.
  - A grant is possible in IDLE, or in RESP in the same cycle that `rsp_valid && rsp_ready`.
- **Accept cycle:**
  - `req_ready[winner]`=1, driven combinationally from `req_valid` and state. All other `req_ready` bits are 0.
  - The handshake completes when both valid and ready are 1.
  - Operand register ← {a, b, sub} of the winner; id register ← winner.
  - Next state is EXEC.
- **EXEC:**
  - The adder is fed from the operand register only.
  - Result register ← adder `s`.
  - Next state is RESP. `req_ready`=0.
- **RESP:**
  - `rsp_valid`=1. `rsp_s` and `rsp_id` come from registers and hold stable until the handshake.
  - On `rsp_ready`=1: `op_count` increments. Next state is EXEC if a new grant occurs that cycle, otherwise IDLE.
  - On `rsp_ready`=0: stay in RESP with no grant; all `req_ready`=0.
- Requesters that are not granted keep waiting. The block never drops or reorders an accepted request.
- Deasserting `req_valid` before grant is legal; that requester is simply skipped.
- There is no arithmetic in this block beyond the mod-N pointer and the 16-bit wrapping counter. The fp result is exactly the adder's output (no rounding or normalisation here).

## Timing
- **Reset:** `rst_n` low forces state IDLE, `ptr`=0, `op_count`=0, and operand/result/id registers to 0. Outputs read `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `busy`=0.
- **Reset mid-operation:** an in-flight transaction is discarded without a response, and the counter is cleared.
- **Latency:** accept at cycle T gives `rsp_valid`=1 from cycle T+2.
- **Throughput:** with `rsp_ready` held at 1, one result every 2 cycles (RESP→EXEC back-to-back).
- **Backpressure:** `rsp_valid`, `rsp_s` and `rsp_id` hold stable while `rsp_ready`=0. No new grant is made during backpressure.
- **Simultaneous valids:** exactly one grant per accept cycle, in round-robin order. With all N_REQ requesters continuously valid, each is served once per N_REQ grants.
- **`busy`:** 1 in EXEC and RESP, 0 in IDLE.

## Test plan
- **Single add:** requester 0 sends a=3F800000, b=40000000, sub=0. Required: `rsp_s`=40400000, `rsp_id`=0, `rsp_valid` exactly 2 cycles after accept, `op_count`=1.
- **Subtract, mixed values:** requester 1 sends a=43E20FCC, b=41AC8ADB, sub=1. Required: `rsp_s`=43D7471E, `rsp_id`=1.
- **Contention:** requesters 0 and 1 both valid from reset with distinct operands (BA9DBB67+4148F5CB, C49A522C+442987E6), `rsp_ready`=1. Required: grants in order 0 then 1, responses 4148F0DD (id 0) then C40B1C72 (id 1), 2 cycles apart. A following round with both valid grants 0 then 1 again (pointer rotates correctly).
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP while requester 1 is valid. Required: `rsp_s`/`rsp_id` stable, all `req_ready`=0. On release, requester 1 is granted in the same cycle as the response handshake.
- **Reset mid-operation:** assert `rst_n`=0 in EXEC. Required: all outputs 0 immediately (asynchronous) and no response after release. The next request is served normally with `op_count` restarting at 1.
- **Cancellation/zero result:** a=3B67BA9D, b=BB67BA9D, sub=0 gives `rsp_s`=00000000. A requester that drops `req_valid` before grant is never granted and produces no response.
